// File: rtl/vector_mem_sequencer.sv
// Shares one word-wide data-memory port between a scalar and a vector load/store
// path; vector accesses are split into LANES sequential word beats.
module vector_mem_sequencer #(
  parameter int V = 128,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_req,
  input  logic         s_wen,
  input  logic [N-1:0] s_addr,
  input  logic [N-1:0] s_wdata,
  input  logic         v_req,
  input  logic         v_wen,
  input  logic [V-1:0] v_addr,
  input  logic [V-1:0] v_wdata,
  input  logic         mem_rdy,
  input  logic [N-1:0] mem_rdata,
  output logic         mem_req,
  output logic         mem_wen,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic         s_done,
  output logic [N-1:0] s_rdata,
  output logic         v_done,
  output logic [V-1:0] v_rdata,
  output logic         stall_cpu,
  output logic [1:0]   dbg_state
);
  localparam int LANES = V / N;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

  // Memory handshake: mem_req/mem_wen/mem_addr/mem_wdata stay stable while
  // mem_req=1; a beat completes in the cycle mem_rdy=1 (mem_rdata valid then).
  typedef enum logic [1:0] {IDLE = 2'd0, SCALAR = 2'd1, VEC = 2'd2, DONE = 2'd3} state_t;

  state_t         state_q, state_d;
  logic [LW-1:0]  lane_q, lane_d;
  logic           last_vec_q, last_vec_d;
  logic           wen_q, wen_d;
  logic [V-1:0]   addr_q, addr_d;
  logic [V-1:0]   wdata_q, wdata_d;
  logic [N-1:0]   s_rdata_q, s_rdata_d;
  logic [V-1:0]   v_rdata_q, v_rdata_d;
  logic           grant_s, grant_v, busy;

  // Contention goes to whichever side was not granted last.
  assign grant_v = v_req & (~s_req | ~last_vec_q);
  assign grant_s = s_req & (~v_req | last_vec_q);
  assign busy    = (state_q == SCALAR) || (state_q == VEC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      last_vec_q <= 1'b1;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      s_rdata_q  <= '0;
      v_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      last_vec_q <= last_vec_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      s_rdata_q  <= s_rdata_d;
      v_rdata_q  <= v_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    last_vec_d = last_vec_q;
    wen_d      = wen_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    s_rdata_d  = s_rdata_q;
    v_rdata_d  = v_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_v) begin
          state_d    = VEC;
          last_vec_d = 1'b1;
          wen_d      = v_wen;
          addr_d     = v_addr;
          wdata_d    = v_wdata;
          lane_d     = '0;
        end else if (grant_s) begin
          // Scalar operands sit in lane 0 so the same lane mux serves both paths.
          state_d    = SCALAR;
          last_vec_d = 1'b0;
          wen_d      = s_wen;
          addr_d     = V'(s_addr);
          wdata_d    = V'(s_wdata);
          lane_d     = '0;
        end
      end
      SCALAR: begin
        if (mem_rdy) begin
          if (!wen_q) s_rdata_d = mem_rdata;
          state_d = DONE;
        end
      end
      VEC: begin
        if (mem_rdy) begin
          if (!wen_q) v_rdata_d[lane_q*N +: N] = mem_rdata;
          if (lane_q == LW'(LANES - 1)) state_d = DONE;
          else                          lane_d  = lane_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = busy;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (busy) begin
      mem_wen  = wen_q;
      mem_addr = addr_q[lane_q*N +: N];
      if (wen_q) mem_wdata = wdata_q[lane_q*N +: N];
    end
    s_done    = (state_q == DONE) & ~last_vec_q;
    v_done    = (state_q == DONE) & last_vec_q;
    stall_cpu = busy | ((state_q == IDLE) & (s_req | v_req));
    dbg_state = state_q;
  end

  assign s_rdata = s_rdata_q;
  assign v_rdata = v_rdata_q;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Bench for vector_mem_sequencer: each transaction is predicted as a list of
// word beats plus the resulting read registers and compared cycle by cycle.
module tb_vector_mem_sequencer;
  localparam int V = 128;
  localparam int N = 32;
  localparam int LANES = V / N;

  logic         clk, rst;
  logic         s_req, s_wen, v_req, v_wen, mem_rdy;
  logic [N-1:0] s_addr, s_wdata, mem_rdata;
  logic [V-1:0] v_addr, v_wdata;
  logic         mem_req, mem_wen, s_done, v_done, stall_cpu;
  logic [N-1:0] mem_addr, mem_wdata, s_rdata;
  logic [V-1:0] v_rdata;
  logic [1:0]   dbg_state;

  int errors = 0;
  int checks = 0;

  // Reference model: result registers and which side was served last.
  logic [N-1:0] model_s;
  logic [V-1:0] model_v;
  bit           model_last_vec;

  vector_mem_sequencer #(.V(V), .N(N)) dut (
    .clk(clk), .rst(rst),
    .s_req(s_req), .s_wen(s_wen), .s_addr(s_addr), .s_wdata(s_wdata),
    .v_req(v_req), .v_wen(v_wen), .v_addr(v_addr), .v_wdata(v_wdata),
    .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .s_done(s_done), .s_rdata(s_rdata), .v_done(v_done), .v_rdata(v_rdata),
    .stall_cpu(stall_cpu), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [V-1:0] rand_v();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    model_s        = '0;
    model_v        = '0;
    model_last_vec = 1'b1;
  endtask

  // Called at the negedge of the IDLE cycle in which the requests are visible.
  task automatic serve(input bit is_vec, input logic [V-1:0] rd_vals, input int stall_beat,
                       input int stall_len, input bit rand_stall, input bit scramble);
    logic [N-1:0] ea[$];
    logic [N-1:0] ed[$];
    bit ew, rdy, finished;
    int nbeats, beat, stalls;
    ew = is_vec ? v_wen : s_wen;
    nbeats = is_vec ? LANES : 1;
    for (int i = 0; i < nbeats; i++) begin
      ea.push_back(is_vec ? v_addr[i*N +: N] : s_addr);
      ed.push_back(ew ? (is_vec ? v_wdata[i*N +: N] : s_wdata) : '0);
    end
    model_last_vec = is_vec;
    beat = 0; stalls = 0; finished = 1'b0;
    #1;
    checks++;
    if (stall_cpu !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL cycle0: stall_cpu=%0b mem_req=%0b, required 1 0", stall_cpu, mem_req);
    end
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (cyc == 1 && scramble) begin
        v_addr = rand_v(); v_wdata = rand_v(); v_wen = ~v_wen;
        s_addr = $urandom; s_wdata = $urandom; s_wen = ~s_wen;
      end
      if (beat < nbeats) begin
        checks++;
        if (mem_req !== 1'b1 || stall_cpu !== 1'b1 || s_done !== 1'b0 || v_done !== 1'b0) begin
          errors++;
          $display("FAIL beat_ctrl cyc%0d: req=%0b stall=%0b sd=%0b vd=%0b, required 1 1 0 0",
                   cyc, mem_req, stall_cpu, s_done, v_done);
        end
        checks++;
        if (mem_addr !== ea[0] || mem_wen !== ew || mem_wdata !== ed[0]) begin
          errors++;
          $display("FAIL beat_bus cyc%0d: addr=%h wen=%0b wdata=%h, required %h %0b %h",
                   cyc, mem_addr, mem_wen, mem_wdata, ea[0], ew, ed[0]);
        end
        if (rand_stall) rdy = ($urandom_range(0, 2) != 0);
        else            rdy = !(beat == stall_beat && stalls < stall_len);
        if (!rdy) stalls++;
        mem_rdy   = rdy;
        mem_rdata = rdy ? rd_vals[beat*N +: N] : $urandom;
        if (rdy) begin
          if (!ew) begin
            if (is_vec) model_v[beat*N +: N] = rd_vals[beat*N +: N];
            else        model_s = rd_vals[N-1:0];
          end
          void'(ea.pop_front());
          void'(ed.pop_front());
          beat++;
        end
      end else begin
        mem_rdy = 1'b0;
        checks++;
        if (s_done !== !is_vec || v_done !== is_vec || mem_req !== 1'b0 || stall_cpu !== 1'b0
            || mem_addr !== '0 || mem_wdata !== '0 || mem_wen !== 1'b0) begin
          errors++;
          $display("FAIL done_cycle: sd=%0b vd=%0b req=%0b stall=%0b addr=%h, required %0b %0b 0 0 0",
                   s_done, v_done, mem_req, stall_cpu, mem_addr, !is_vec, is_vec);
        end
        checks++;
        if (s_rdata !== model_s || v_rdata !== model_v) begin
          errors++;
          $display("FAIL rdata: s=%h v=%h, required s=%h v=%h", s_rdata, v_rdata, model_s, model_v);
        end
        checks++;
        if (cyc != nbeats + stalls + 1) begin
          errors++;
          $display("FAIL done_latency: cycle=%0d, required %0d", cyc, nbeats + stalls + 1);
        end
        if (is_vec) v_req = 1'b0;
        else        s_req = 1'b0;
        finished = 1'b1;
        break;
      end
    end
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done after 200 cycles, required done");
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || mem_wen !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
        s_done !== 1'b0 || v_done !== 1'b0 || stall_cpu !== 1'b0 || s_rdata !== '0 || v_rdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%0b stall=%0b sr=%h vr=%h, required all zero",
               mem_req, stall_cpu, s_rdata, v_rdata);
    end
    rst = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    s_req = 1'b1; s_wen = 1'b0; s_addr = 32'h100; s_wdata = $urandom;
    v_req = 1'b1; v_wen = 1'b0; v_addr = rand_v(); v_wdata = rand_v();
    serve(1'b0, rand_v(), -1, 0, 1'b0, 1'b0);
    @(negedge clk);
    serve(1'b1, rand_v(), -1, 0, 1'b0, 1'b0);
    @(negedge clk);
    s_req = 1'b1; v_req = 1'b1; s_addr = 32'h104; v_addr = rand_v();
    serve(1'b0, rand_v(), -1, 0, 1'b0, 1'b0);
    @(negedge clk);
    serve(1'b1, rand_v(), -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_scalar_load();
    @(negedge clk);
    s_req = 1'b1; s_wen = 1'b0; s_addr = 32'h40; s_wdata = $urandom;
    serve(1'b0, V'(32'h1234), -1, 0, 1'b0, 1'b0);
    checks++;
    if (s_rdata !== 32'h1234) begin
      errors++;
      $display("FAIL scalar_rdata: %h, required 00001234", s_rdata);
    end
  endtask

  task automatic test_vector_load();
    @(negedge clk);
    v_req = 1'b1; v_wen = 1'b0;
    v_addr = 128'h0000001C_00000018_00000014_00000010; v_wdata = rand_v();
    serve(1'b1, 128'h0000000D_0000000C_0000000B_0000000A, -1, 0, 1'b0, 1'b0);
    checks++;
    if (v_rdata !== 128'h0000000D_0000000C_0000000B_0000000A) begin
      errors++;
      $display("FAIL vector_rdata: %h, required 0000000d0000000c0000000b0000000a", v_rdata);
    end
  endtask

  task automatic test_vector_store_stall();
    @(negedge clk);
    v_req = 1'b1; v_wen = 1'b1; v_addr = rand_v(); v_wdata = rand_v();
    serve(1'b1, rand_v(), 0, 2, 1'b0, 1'b0);
  endtask

  task automatic test_latch_operands();
    @(negedge clk);
    v_req = 1'b1; v_wen = 1'b0; v_addr = rand_v(); v_wdata = rand_v();
    serve(1'b1, rand_v(), -1, 0, 1'b0, 1'b1);
    @(negedge clk);
    s_req = 1'b1; s_wen = 1'b1; s_addr = $urandom; s_wdata = $urandom;
    serve(1'b0, rand_v(), -1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    bit want_s, want_v, first_vec;
    for (int it = 0; it < 25; it++) begin
      @(negedge clk);
      want_s = $urandom_range(0, 1);
      want_v = want_s ? $urandom_range(0, 1) : 1'b1;
      s_wen = $urandom_range(0, 1); s_addr = $urandom; s_wdata = $urandom;
      v_wen = $urandom_range(0, 1); v_addr = rand_v(); v_wdata = rand_v();
      s_req = want_s; v_req = want_v;
      first_vec = (want_s && want_v) ? !model_last_vec : want_v;
      serve(first_vec, rand_v(), -1, 0, 1'b1, 1'b0);
      if (want_s && want_v) begin
        @(negedge clk);
        serve(!first_vec, rand_v(), -1, 0, 1'b1, 1'b0);
      end
    end
  endtask

  task automatic test_reset_mid_vec();
    @(negedge clk);
    v_req = 1'b1; v_wen = 1'b0; v_addr = rand_v(); v_wdata = rand_v();
    @(negedge clk);
    mem_rdy = 1'b1; mem_rdata = $urandom;
    @(negedge clk);
    rst = 1'b0; v_req = 1'b0; mem_rdy = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || stall_cpu !== 1'b0 || v_rdata !== '0 || s_rdata !== '0 ||
        v_done !== 1'b0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_mid_vec: req=%0b stall=%0b vr=%h vd=%0b, required 0 0 0 0",
               mem_req, stall_cpu, v_rdata, v_done);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (v_done !== 1'b0 || s_done !== 1'b0 || mem_req !== 1'b0 || stall_cpu !== 1'b0) begin
        errors++;
        $display("FAIL after_reset cyc%0d: vd=%0b req=%0b stall=%0b, required 0 0 0",
                 c, v_done, mem_req, stall_cpu);
      end
    end
    // Fresh arbitration state: contention must go to the scalar side again.
    s_req = 1'b1; v_req = 1'b1; s_wen = 1'b0; v_wen = 1'b0;
    serve(1'b0, rand_v(), -1, 0, 1'b0, 1'b0);
    @(negedge clk);
    serve(1'b1, rand_v(), -1, 0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    s_req = 1'b0; s_wen = 1'b0; s_addr = '0; s_wdata = '0;
    v_req = 1'b0; v_wen = 1'b0; v_addr = '0; v_wdata = '0;
    mem_rdy = 1'b0; mem_rdata = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_arbitration();
    test_scalar_load();
    test_vector_load();
    test_vector_store_stall();
    test_latch_operands();
    test_random();
    test_reset_mid_vec();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
